voice_operator_scheduler: RTL and testbench

Issues the voice-operator ID stream that drives the modulator and operator pipeline: one ID per clock, voice-fastest, 256 IDs per sample frame. Buffers host configuration writes (algorithm words and other per-operator registers) in a small FIFO. Commits them only between frames, after the pipeline has drained, so no operator sees a half-updated algorithm mid-frame. Sits between the host config interface and the head of the synth pipeline.

---
 rtl/voice_operator_scheduler_pkg.sv | 57 +++++
 rtl/voice_operator_scheduler_cfg_write_fifo.sv | 64 ++++++
 rtl/voice_operator_scheduler.sv | 167 ++++++++++++++++
 tb/tb_voice_operator_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_operator_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : voice_operator_scheduler_pkg                               |
// | Description : Shared types and helpers for the voice-operator scheduler  |
// |               and the synth pipeline it feeds.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package voice_operator_scheduler_pkg;

   localparam int NUM_VOICE_OPERATORS = 256;
   localparam int VOICE_ID_W          = 5;
   localparam int OPERATOR_ID_W       = 3;
   localparam int CFG_KIND_W          = 2;
   localparam int CFG_ADDR_W          = 8;
   localparam int CFG_DATA_W          = 16;
   localparam int CFG_PAYLOAD_W       = CFG_KIND_W + CFG_ADDR_W + CFG_DATA_W;

   // {op[2:0], voice[4:0]}
   typedef logic [OPERATOR_ID_W+VOICE_ID_W-1:0] VoiceOperatorID_t;

   typedef enum logic [1:0] {
      CFG_ALGORITHM  = 2'd0,
      CFG_PHASE_STEP = 2'd1,
      CFG_ENVELOPE   = 2'd2,
      CFG_RESERVED   = 2'd3
   } ConfigKind_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } SchedState_t;

   function automatic logic [VOICE_ID_W-1:0] getVoiceID(input VoiceOperatorID_t id);
      return id[VOICE_ID_W-1:0];
   endfunction

   function automatic logic [OPERATOR_ID_W-1:0] getOperatorID(input VoiceOperatorID_t id);
      return id[OPERATOR_ID_W+VOICE_ID_W-1:VOICE_ID_W];
   endfunction

   // Reserved kind maps to no enable so the entry is silently dropped.
   function automatic logic [3:0] kindToEnable(input ConfigKind_t kind);
      logic [3:0] en;
      en = 4'b0000;
      case (kind)
         CFG_ALGORITHM:  en = 4'b0001;
         CFG_PHASE_STEP: en = 4'b0010;
         CFG_ENVELOPE:   en = 4'b0100;
         default:        en = 4'b0000;
      endcase
      return en;
   endfunction

endpackage
`default_nettype wire

// File: rtl/voice_operator_scheduler_cfg_write_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_write_fifo                                             |
// | Description : Small synchronous FIFO holding host config writes until    |
// |               the scheduler reaches a frame boundary.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cfg_write_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 26
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // Advance each pointer on an accepted push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers; reset empties the FIFO and discards pending writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/voice_operator_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : voice_operator_scheduler                                   |
// | Description : Issues one voice-operator ID per clock (256 per frame) and |
// |               commits buffered host config writes only between frames,  |
// |               after the synth pipeline has drained.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module voice_operator_scheduler
   import voice_operator_scheduler_pkg::*;
#(
   parameter int NUM_VOICES     = 32,
   parameter int NUM_OPERATORS  = 8,
   parameter int PIPELINE_DEPTH = 16,
   parameter int CFG_FIFO_DEPTH = 4
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Enable,
   input  logic        i_CfgValid,
   output logic        o_CfgReady,
   input  logic [1:0]  i_CfgKind,
   input  logic [7:0]  i_CfgAddr,
   input  logic [15:0] i_CfgData,
   output logic [7:0]  o_VoiceOperator,
   output logic        o_Valid,
   output logic        o_FrameStart,
   output logic [3:0]  o_ConfigWriteEnable,
   output logic [7:0]  o_ConfigWriteAddr,
   output logic [15:0] o_ConfigWriteData,
   output logic        o_Busy
);

   localparam VoiceOperatorID_t LAST_ID = VoiceOperatorID_t'(NUM_VOICES * NUM_OPERATORS - 1);
   localparam int               DRAIN_W = $clog2(PIPELINE_DEPTH) + 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPELINE_DEPTH - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = 1;
   localparam VoiceOperatorID_t   ID_ONE     = 1;

   SchedState_t              state_q, state_d;
   VoiceOperatorID_t         vo_q, vo_d;
   logic                     valid_q, valid_d;
   logic                     fs_q, fs_d;
   logic                     busy_q, busy_d;
   logic [DRAIN_W-1:0]       drain_q, drain_d;
   logic [3:0]               we_q, we_d;
   logic [CFG_ADDR_W-1:0]    waddr_q, waddr_d;
   logic [CFG_DATA_W-1:0]    wdata_q, wdata_d;

   logic                     fifo_push;
   logic                     fifo_pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CFG_PAYLOAD_W-1:0] fifo_rd_data;
   ConfigKind_t              pop_kind;

   assign o_CfgReady = !fifo_full && !i_Reset;
   assign fifo_push  = i_CfgValid && o_CfgReady;
   assign pop_kind   = ConfigKind_t'(fifo_rd_data[CFG_PAYLOAD_W-1 -: CFG_KIND_W]);

   cfg_write_fifo #(
      .DEPTH (CFG_FIFO_DEPTH),
      .WIDTH (CFG_PAYLOAD_W)
   ) u_cfg_write_fifo (
      .clk_i       (i_Clock),
      .rst_i       (i_Reset),
      .push_i      (fifo_push),
      .push_data_i ({i_CfgKind, i_CfgAddr, i_CfgData}),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_rd_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Next-state and registered-output decode. Each output register is loaded
   // with what the coming cycle shows, so a pop at the edge entering a COMMIT
   // cycle presents its write during that COMMIT cycle.
   always_comb begin
      state_d  = state_q;
      vo_d     = vo_q;
      valid_d  = 1'b0;
      fs_d     = 1'b0;
      drain_d  = drain_q;
      we_d     = 4'b0000;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      fifo_pop = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty)   state_d = ST_COMMIT;
            else if (i_Enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            // Enable and pending writes only matter on the last ID of a frame.
            if (vo_q == LAST_ID) begin
               if (!fifo_empty) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end else if (!i_Enable) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) state_d = ST_COMMIT;
            else               drain_d = drain_q - DRAIN_ONE;
         end
         ST_COMMIT: begin
            // Stay while writes remain, including ones pushed during COMMIT.
            if (fifo_empty) state_d = i_Enable ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_COMMIT && !fifo_empty) begin
         fifo_pop = 1'b1;
         we_d     = kindToEnable(pop_kind);
         waddr_d  = fifo_rd_data[CFG_DATA_W +: CFG_ADDR_W];
         wdata_d  = fifo_rd_data[CFG_DATA_W-1:0];
      end

      // Every entry into RUN starts a fresh frame at ID 0.
      if (state_d == ST_RUN) begin
         valid_d = 1'b1;
         vo_d    = (state_q == ST_RUN && vo_q != LAST_ID) ? vo_q + ID_ONE : '0;
         fs_d    = (vo_d == '0);
      end

      busy_d = (state_d == ST_DRAIN) || (state_d == ST_COMMIT);
   end

   // State and output registers.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
         vo_q    <= '0;
         valid_q <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
         drain_q <= '0;
         we_q    <= 4'b0000;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         vo_q    <= vo_d;
         valid_q <= valid_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
         drain_q <= drain_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign o_VoiceOperator     = vo_q;
   assign o_Valid             = valid_q;
   assign o_FrameStart        = fs_q;
   assign o_Busy              = busy_q;
   assign o_ConfigWriteEnable = we_q;
   assign o_ConfigWriteAddr   = waddr_q;
   assign o_ConfigWriteData   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_operator_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_voice_operator_scheduler                                |
// | Description : Self-checking bench for voice_operator_scheduler with a    |
// |               commit scoreboard and an ID-sequence monitor.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_voice_operator_scheduler;

   localparam int PD = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_Enable;
   logic        i_CfgValid;
   logic        o_CfgReady;
   logic [1:0]  i_CfgKind;
   logic [7:0]  i_CfgAddr;
   logic [15:0] i_CfgData;
   logic [7:0]  o_VoiceOperator;
   logic        o_Valid;
   logic        o_FrameStart;
   logic [3:0]  o_ConfigWriteEnable;
   logic [7:0]  o_ConfigWriteAddr;
   logic [15:0] o_ConfigWriteData;
   logic        o_Busy;

   typedef struct packed {
      logic [3:0]  we;
      logic [7:0]  addr;
      logic [15:0] data;
   } commit_t;

   commit_t exp_q[$];
   int      n_checks = 0;
   int      n_fail   = 0;

   voice_operator_scheduler #(
      .NUM_VOICES     (32),
      .NUM_OPERATORS  (8),
      .PIPELINE_DEPTH (PD),
      .CFG_FIFO_DEPTH (4)
   ) dut (
      .i_Clock             (clk),
      .i_Reset             (rst),
      .i_Enable            (i_Enable),
      .i_CfgValid          (i_CfgValid),
      .o_CfgReady          (o_CfgReady),
      .i_CfgKind           (i_CfgKind),
      .i_CfgAddr           (i_CfgAddr),
      .i_CfgData           (i_CfgData),
      .o_VoiceOperator     (o_VoiceOperator),
      .o_Valid             (o_Valid),
      .o_FrameStart        (o_FrameStart),
      .o_ConfigWriteEnable (o_ConfigWriteEnable),
      .o_ConfigWriteAddr   (o_ConfigWriteAddr),
      .o_ConfigWriteData   (o_ConfigWriteData),
      .o_Busy              (o_Busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] next_id(input logic prev_valid, input logic [7:0] last);
      logic [7:0] n;
      n = last + 8'd1;
      return prev_valid ? n : 8'd0;
   endfunction

   // ID-sequence monitor: contiguous IDs within a run, ID 0 after any gap,
   // frame start exactly with ID 0, commit enables one-hot.
   logic       mon_prev_valid = 1'b0;
   logic [7:0] mon_last       = 8'd0;
   always @(negedge clk) begin
      if (rst) begin
         mon_prev_valid <= 1'b0;
      end else begin
         if (o_Valid) begin
            check_eq("id_seq", o_VoiceOperator, next_id(mon_prev_valid, mon_last));
            check_eq("frame_start", o_FrameStart, next_id(mon_prev_valid, mon_last) == 8'd0);
         end else begin
            check_eq("fs_when_idle", o_FrameStart, 1'b0);
         end
         if (o_ConfigWriteEnable != 4'b0000)
            check_eq("we_onehot", $countones(o_ConfigWriteEnable), 1);
         mon_prev_valid <= o_Valid;
         mon_last       <= o_VoiceOperator;
      end
   end

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic push_one(input logic [1:0] kind, input logic [7:0] addr, input logic [15:0] data);
      commit_t e;
      int      t;
      i_CfgValid = 1'b1;
      i_CfgKind  = kind;
      i_CfgAddr  = addr;
      i_CfgData  = data;
      t = 0;
      while (!o_CfgReady && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!o_CfgReady) begin
         check_eq("push_timeout", 1'b0, 1'b1);
         i_CfgValid = 1'b0;
         return;
      end
      @(posedge clk);
      e.we   = (kind == 2'd3) ? 4'b0000 : (4'b0001 << kind);
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_id(input logic [7:0] id);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(o_Valid && o_VoiceOperator == id) && t < 1000);
      check_eq("wait_id", {o_Valid, o_VoiceOperator}, {1'b1, id});
   endtask

   // From the last ID of the current frame: drain window, n commits, then
   // either an immediate new frame or idle.
   task automatic expect_commit(input int n, input logic run_after);
      commit_t e;
      wait_id(8'd255);
      for (int i = 0; i < PD; i++) begin
         @(negedge clk);
         check_eq("drain", {o_Valid, o_Busy, o_ConfigWriteEnable}, {1'b0, 1'b1, 4'b0000});
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            check_eq("commit_exp_empty", 1'b0, 1'b1);
         end else begin
            e = exp_q.pop_front();
            check_eq("commit_we", {o_Valid, o_Busy, o_ConfigWriteEnable}, {1'b0, 1'b1, e.we});
            if (e.we != 4'b0000)
               check_eq("commit_addr_data", {o_ConfigWriteAddr, o_ConfigWriteData}, {e.addr, e.data});
         end
      end
      @(negedge clk);
      if (run_after)
         check_eq("resume", {o_Valid, o_FrameStart, o_VoiceOperator, o_Busy, o_ConfigWriteEnable},
                  {1'b1, 1'b1, 8'd0, 1'b0, 4'b0000});
      else
         check_eq("after_commit_idle", {o_Valid, o_Busy, o_ConfigWriteEnable}, {1'b0, 1'b0, 4'b0000});
   endtask

   function automatic logic [39:0] all_outputs();
      return {o_CfgReady, o_VoiceOperator, o_Valid, o_FrameStart, o_ConfigWriteEnable,
              o_ConfigWriteAddr, o_ConfigWriteData, o_Busy};
   endfunction

   initial begin
      int cnt_v;
      int cnt_fs;
      rst        = 1'b1;
      i_Enable   = 1'b0;
      i_CfgValid = 1'b0;
      i_CfgKind  = 2'd0;
      i_CfgAddr  = 8'd0;
      i_CfgData  = 16'd0;

      // Reset state
      #1;
      check_eq("reset_outputs", all_outputs(), 40'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_reset", {o_CfgReady, o_Valid, o_Busy, o_ConfigWriteEnable}, {1'b1, 1'b0, 1'b0, 4'b0000});

      // Free run, no config: valid one cycle after enable, no gaps
      i_Enable = 1'b1;
      @(negedge clk);
      check_eq("first_issue", {o_Valid, o_FrameStart, o_VoiceOperator}, {1'b1, 1'b1, 8'd0});
      cnt_v  = 0;
      cnt_fs = 0;
      for (int i = 1; i < 512; i++) begin
         @(negedge clk);
         if (o_Valid)      cnt_v++;
         if (o_FrameStart) cnt_fs++;
      end
      check_eq("run_no_gaps", cnt_v, 511);
      check_eq("run_frame_starts", cnt_fs, 1);

      // Single algorithm write mid-frame
      wait_id(8'd50);
      push_one(2'd0, 8'h23, 16'h0155);
      i_CfgValid = 1'b0;
      expect_commit(1, 1'b1);

      // Five back-to-back writes: FIFO fills at 4, fifth lands during COMMIT
      wait_id(8'd20);
      fork
         begin
            push_one(2'd0, 8'h01, 16'h1111);
            push_one(2'd1, 8'h02, 16'h2222);
            push_one(2'd2, 8'h03, 16'h3333);
            push_one(2'd1, 8'h04, 16'h4444);
            check_eq("ready_full", o_CfgReady, 1'b0);
            push_one(2'd2, 8'h05, 16'h5555);
            i_CfgValid = 1'b0;
         end
         expect_commit(5, 1'b1);
      join

      // Reserved kind between two phase-step writes
      wait_id(8'd30);
      push_one(2'd1, 8'h11, 16'hAAAA);
      push_one(2'd3, 8'h22, 16'hBBBB);
      push_one(2'd1, 8'h33, 16'hCCCC);
      i_CfgValid = 1'b0;
      expect_commit(3, 1'b1);

      // Disable mid-frame: frame completes, then idle; re-enable restarts at 0
      wait_id(8'd100);
      i_Enable = 1'b0;
      wait_id(8'd255);
      @(negedge clk);
      check_eq("disable_idle", {o_Valid, o_Busy}, 2'b00);
      cnt_v = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_Valid || o_Busy) cnt_v++;
      end
      check_eq("idle_quiet", cnt_v, 0);
      check_eq("idle_holds_id", o_VoiceOperator, 8'd255);
      i_Enable = 1'b1;
      @(negedge clk);
      check_eq("restart", {o_Valid, o_FrameStart, o_VoiceOperator}, {1'b1, 1'b1, 8'd0});

      // Asynchronous reset during DRAIN with writes queued
      wait_id(8'd40);
      push_one(2'd0, 8'h41, 16'h0041);
      push_one(2'd1, 8'h42, 16'h0042);
      push_one(2'd2, 8'h43, 16'h0043);
      i_CfgValid = 1'b0;
      wait_id(8'd255);
      repeat (5) @(negedge clk);
      check_eq("in_drain", {o_Valid, o_Busy}, 2'b01);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_reset_outputs", all_outputs(), 40'd0);
      exp_q.delete();
      i_Enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt_v = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_Valid || o_Busy || (o_ConfigWriteEnable != 4'b0000)) cnt_v++;
      end
      check_eq("reset_fifo_empty", cnt_v, 0);
      check_eq("reset_ready", o_CfgReady, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
